// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the register file with pending-write scoreboard.
// No logic here; the clear sequencer and the top both import this package.
// The sequencer and the top use the clear-state enum. The defaults size both modules.
package reg_file_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 4;

    typedef enum logic [1:0] {
        CLR_IDLE  = 2'd0,
        CLR_CLEAR = 2'd1,
        CLR_DONE  = 2'd2
    } clr_state_t;

endpackage

// File: rtl/reg_file_clear_seq.sv
// Bulk-clear sequencer: walks an index over every register, one entry per cycle.
// Latency: busy for DEPTH cycles after the start edge, then a one-cycle done pulse.
// No backpressure: a start request seen outside IDLE is dropped, not queued.
module reg_file_clear_seq
    import reg_file_pkg::*;
#(
    parameter  int DEPTH = DEFAULT_DEPTH,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          Clock,
    input  logic          Reset_n,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic [AW-1:0] idx
);

    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    clr_state_t state;
    clr_state_t state_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            CLR_IDLE:  if (start) state_nxt = CLR_CLEAR;
            CLR_CLEAR: if (idx == LAST_IDX) state_nxt = CLR_DONE;
            CLR_DONE:  state_nxt = CLR_IDLE;
            default:   state_nxt = CLR_IDLE;
        endcase
    end

    // busy/done come straight from flops so downstream sees glitch-free status.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            state <= CLR_IDLE;
            idx   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            state <= state_nxt;
            busy  <= (state_nxt == CLR_CLEAR);
            done  <= (state_nxt == CLR_DONE);
            if (state == CLR_IDLE && start) begin
                idx <= '0;
            end else if (state == CLR_CLEAR) begin
                idx <= idx + AW'(1);
            end
        end
    end

endmodule

// File: rtl/reg_file_scoreboard.sv
// Two-read/one-write register file with per-entry pending bits and write-through bypass.
// Latency: reads combinational; writes/reserves take effect at the next rising edge.
// No backpressure: writes and reserves issued while a bulk clear runs are discarded.
module reg_file_scoreboard
    import reg_file_pkg::*;
#(
    parameter  int WIDTH    = DEFAULT_WIDTH,
    parameter  int DEPTH    = DEFAULT_DEPTH,
    parameter  bit ZERO_REG = 1'b0,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic             Clock,
    input  logic             Reset_n,
    input  logic             Write_Enable,
    input  logic [AW-1:0]    Write_Address,
    input  logic [WIDTH-1:0] Write_Data,
    input  logic             Reserve_Enable,
    input  logic [AW-1:0]    Reserve_Address,
    input  logic [AW-1:0]    Read_Address1,
    input  logic [AW-1:0]    Read_Address2,
    output logic [WIDTH-1:0] Read_Data1,
    output logic [WIDTH-1:0] Read_Data2,
    output logic             Read_Ready1,
    output logic             Read_Ready2,
    input  logic             Clear_Start,
    output logic             Clear_Busy,
    output logic             Clear_Done
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] busy;

    logic          clr_busy;
    logic [AW-1:0] clr_idx;
    logic          we_eff;
    logic          rsv_eff;

    reg_file_clear_seq #(
        .DEPTH (DEPTH)
    ) u_clear_seq (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .start   (Clear_Start),
        .busy    (clr_busy),
        .done    (Clear_Done),
        .idx     (clr_idx)
    );

    assign Clear_Busy = clr_busy;

    // A hardwired-zero register 0 swallows writes and reserves aimed at it.
    assign we_eff  = Write_Enable && !clr_busy &&
                     !(ZERO_REG && (Write_Address == '0));
    assign rsv_eff = Reserve_Enable && !clr_busy &&
                     !(ZERO_REG && (Reserve_Address == '0));

    // Reserve is applied after write so a same-address pair leaves the entry pending.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else if (clr_busy) begin
            regs[clr_idx] <= '0;
            busy[clr_idx] <= 1'b0;
        end else begin
            if (we_eff) begin
                regs[Write_Address] <= Write_Data;
                busy[Write_Address] <= 1'b0;
            end
            if (rsv_eff) begin
                busy[Reserve_Address] <= 1'b1;
            end
        end
    end

    logic [AW-1:0]    raddr [2];
    logic [WIDTH-1:0] rdata [2];
    logic             rrdy  [2];

    assign raddr[0] = Read_Address1;
    assign raddr[1] = Read_Address2;

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            rdata[p] = regs[raddr[p]];
            rrdy[p]  = !busy[raddr[p]];
            if (ZERO_REG && (raddr[p] == '0)) begin
                rdata[p] = '0;
                rrdy[p]  = 1'b1;
            end else if (we_eff && (Write_Address == raddr[p])) begin
                rdata[p] = Write_Data;
                rrdy[p]  = 1'b1;
            end
        end
    end

    assign Read_Data1  = rdata[0];
    assign Read_Data2  = rdata[1];
    assign Read_Ready1 = rrdy[0];
    assign Read_Ready2 = rrdy[1];

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Bench for reg_file_scoreboard: two instances (ZERO_REG=0 and 1) share stimulus;
// a cycle-numbered behavioural model is compared every cycle, plus directed literal checks.
module tb_reg_file_scoreboard;

    localparam int DEPTH = 4;

    logic        Clock = 1'b0;
    logic        Reset_n = 1'b0;
    logic        Write_Enable = 1'b0;
    logic [1:0]  Write_Address = '0;
    logic [15:0] Write_Data = '0;
    logic        Reserve_Enable = 1'b0;
    logic [1:0]  Reserve_Address = '0;
    logic [1:0]  Read_Address1 = '0;
    logic [1:0]  Read_Address2 = '0;
    logic        Clear_Start = 1'b0;

    logic [15:0] a_rd1, a_rd2, b_rd1, b_rd2;
    logic        a_rdy1, a_rdy2, b_rdy1, b_rdy2;
    logic        a_busy, a_done, b_busy, b_done;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    reg_file_scoreboard #(.WIDTH(16), .DEPTH(DEPTH), .ZERO_REG(1'b0)) dut_a (
        .Clock(Clock), .Reset_n(Reset_n),
        .Write_Enable(Write_Enable), .Write_Address(Write_Address), .Write_Data(Write_Data),
        .Reserve_Enable(Reserve_Enable), .Reserve_Address(Reserve_Address),
        .Read_Address1(Read_Address1), .Read_Address2(Read_Address2),
        .Read_Data1(a_rd1), .Read_Data2(a_rd2), .Read_Ready1(a_rdy1), .Read_Ready2(a_rdy2),
        .Clear_Start(Clear_Start), .Clear_Busy(a_busy), .Clear_Done(a_done)
    );

    reg_file_scoreboard #(.WIDTH(16), .DEPTH(DEPTH), .ZERO_REG(1'b1)) dut_b (
        .Clock(Clock), .Reset_n(Reset_n),
        .Write_Enable(Write_Enable), .Write_Address(Write_Address), .Write_Data(Write_Data),
        .Reserve_Enable(Reserve_Enable), .Reserve_Address(Reserve_Address),
        .Read_Address1(Read_Address1), .Read_Address2(Read_Address2),
        .Read_Data1(b_rd1), .Read_Data2(b_rd2), .Read_Ready1(b_rdy1), .Read_Ready2(b_rdy2),
        .Clear_Start(Clear_Start), .Clear_Busy(b_busy), .Clear_Done(b_done)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: cycle c is the cycle following rising edge c; a clear accepted at edge k
    // keeps busy for cycles k..k+DEPTH-1 and pulses done in cycle k+DEPTH.
    logic [15:0] mm [2][DEPTH];
    bit          mb [2][DEPTH];
    int          cyc = 0;
    int          k   = -100;

    function automatic bit m_busy(input int c);
        return ((c - k) >= 0) && ((c - k) < DEPTH);
    endfunction

    function automatic bit m_done(input int c);
        return (c - k) == DEPTH;
    endfunction

    always @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int z = 0; z < 2; z++)
                for (int i = 0; i < DEPTH; i++) begin
                    mm[z][i] = '0;
                    mb[z][i] = 1'b0;
                end
            k = -100;
        end else begin
            int prev;
            prev = cyc;
            cyc  = cyc + 1;
            if (m_busy(prev)) begin
                for (int z = 0; z < 2; z++) begin
                    mm[z][prev - k] = '0;
                    mb[z][prev - k] = 1'b0;
                end
            end else begin
                for (int z = 0; z < 2; z++) begin
                    if (Write_Enable && !(z == 1 && Write_Address == 2'd0)) begin
                        mm[z][Write_Address] = Write_Data;
                        mb[z][Write_Address] = 1'b0;
                    end
                    if (Reserve_Enable && !(z == 1 && Reserve_Address == 2'd0))
                        mb[z][Reserve_Address] = 1'b1;
                end
            end
            if (Clear_Start && !m_busy(prev) && !m_done(prev)) k = cyc;
        end
    end

    task automatic exp_rd(input int z, input logic [1:0] a,
                          output logic [15:0] d, output logic r);
        if (z == 1 && a == 2'd0) begin
            d = '0; r = 1'b1;
        end else if (Write_Enable && !m_busy(cyc) && Write_Address == a) begin
            d = Write_Data; r = 1'b1;
        end else begin
            d = mm[z][a]; r = !mb[z][a];
        end
    endtask

    always @(negedge Clock) begin
        logic [15:0] d;
        logic        r;
        chk("a_clear_busy", 32'(a_busy), 32'(m_busy(cyc) && Reset_n));
        chk("a_clear_done", 32'(a_done), 32'(m_done(cyc) && Reset_n));
        chk("b_clear_busy", 32'(b_busy), 32'(m_busy(cyc) && Reset_n));
        chk("b_clear_done", 32'(b_done), 32'(m_done(cyc) && Reset_n));
        if (Reset_n) begin
            exp_rd(0, Read_Address1, d, r); chk("a_rd1", 32'(a_rd1), 32'(d)); chk("a_rdy1", 32'(a_rdy1), 32'(r));
            exp_rd(0, Read_Address2, d, r); chk("a_rd2", 32'(a_rd2), 32'(d)); chk("a_rdy2", 32'(a_rdy2), 32'(r));
            exp_rd(1, Read_Address1, d, r); chk("b_rd1", 32'(b_rd1), 32'(d)); chk("b_rdy1", 32'(b_rdy1), 32'(r));
            exp_rd(1, Read_Address2, d, r); chk("b_rd2", 32'(b_rd2), 32'(d)); chk("b_rdy2", 32'(b_rdy2), 32'(r));
        end
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic idle_inputs();
        Write_Enable = 1'b0; Reserve_Enable = 1'b0; Clear_Start = 1'b0;
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_done", 32'(a_done), 32'd0);
        chk("rst_rd1", 32'(a_rd1), 32'd0);
        tick(); tick();
        Reset_n = 1'b1;

        // Plain write then dual-port read
        Write_Enable = 1'b1; Write_Address = 2'd2; Write_Data = 16'hA5A5;
        tick();
        idle_inputs(); Read_Address1 = 2'd2; Read_Address2 = 2'd2;
        @(negedge Clock);
        chk("rd_r2_p1", 32'(a_rd1), 32'hA5A5);
        chk("rd_r2_p2", 32'(a_rd2), 32'hA5A5);
        chk("rdy_r2", 32'({a_rdy1, a_rdy2}), 32'b11);
        tick();

        // Same-cycle bypass
        Write_Enable = 1'b1; Write_Address = 2'd3; Write_Data = 16'h1234; Read_Address1 = 2'd3;
        @(negedge Clock);
        chk("bypass_r3", 32'(a_rd1), 32'h1234);
        chk("bypass_rdy", 32'(a_rdy1), 32'd1);
        tick();

        // Reserve / write / simultaneous reserve+write on r1
        idle_inputs(); Reserve_Enable = 1'b1; Reserve_Address = 2'd1;
        tick();
        idle_inputs(); Read_Address1 = 2'd1;
        @(negedge Clock);
        chk("rsv_rdy0", 32'(a_rdy1), 32'd0);
        tick();
        Write_Enable = 1'b1; Write_Address = 2'd1; Write_Data = 16'h0042;
        @(negedge Clock);
        chk("wr_rdy1", 32'(a_rdy1), 32'd1);
        chk("wr_byp", 32'(a_rd1), 32'h0042);
        tick();
        Reserve_Enable = 1'b1; Reserve_Address = 2'd1;
        tick();
        idle_inputs();
        @(negedge Clock);
        chk("rw_data", 32'(a_rd1), 32'h0042);
        chk("rw_rdy0", 32'(a_rdy1), 32'd0);
        tick();

        // Hardwired zero register
        Write_Enable = 1'b1; Write_Address = 2'd0; Write_Data = 16'hFFFF; Read_Address1 = 2'd0;
        @(negedge Clock);
        chk("z_byp_none", 32'(b_rd1), 32'd0);
        chk("nz_byp", 32'(a_rd1), 32'hFFFF);
        tick();
        idle_inputs();
        @(negedge Clock);
        chk("z_r0", 32'(b_rd1), 32'd0);
        chk("z_r0_rdy", 32'(b_rdy1), 32'd1);
        tick();

        // Fill then bulk clear
        for (int i = 0; i < DEPTH; i++) begin
            Write_Enable = 1'b1; Write_Address = 2'(i); Write_Data = 16'(16'h1111 * (i + 1));
            tick();
        end
        idle_inputs(); Clear_Start = 1'b1;
        tick();
        Clear_Start = 1'b0;
        for (int c = 0; c < DEPTH; c++) begin
            if (c == 1) begin
                Write_Enable = 1'b1; Write_Address = 2'd0; Write_Data = 16'h7777; Clear_Start = 1'b1;
            end
            @(negedge Clock);
            chk("clr_busy", 32'(a_busy), 32'd1);
            chk("clr_nodone", 32'(a_done), 32'd0);
            tick();
            idle_inputs();
        end
        @(negedge Clock);
        chk("clr_done", 32'(a_done), 32'd1);
        chk("clr_busy_off", 32'(a_busy), 32'd0);
        tick();
        @(negedge Clock);
        chk("post_busy", 32'(a_busy), 32'd0);
        chk("post_done", 32'(a_done), 32'd0);
        for (int i = 0; i < DEPTH; i++) begin
            Read_Address1 = 2'(i); Read_Address2 = 2'(i);
            #1;
            chk("clr_rd1", 32'(a_rd1), 32'd0);
            chk("clr_rd2", 32'(b_rd2), 32'd0);
        end
        tick();

        // Reset in the middle of a clear
        for (int i = 0; i < DEPTH; i++) begin
            Write_Enable = 1'b1; Write_Address = 2'(i); Write_Data = 16'hBEEF;
            tick();
        end
        idle_inputs(); Clear_Start = 1'b1;
        tick();
        Clear_Start = 1'b0;
        tick(); tick();
        Read_Address1 = 2'd3;
        Reset_n = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(a_busy), 32'd0);
        chk("mid_rst_done", 32'(a_done), 32'd0);
        chk("mid_rst_rd", 32'(a_rd1), 32'd0);
        tick();
        Reset_n = 1'b1;
        for (int c = 0; c < DEPTH + 2; c++) begin
            @(negedge Clock);
            chk("no_done_after_rst", 32'(a_done), 32'd0);
            tick();
        end

        // Randomised traffic
        for (int n = 0; n < 3000; n++) begin
            Reset_n         = 1'b1;
            Write_Enable    = 1'($urandom_range(0, 1));
            Write_Address   = 2'($urandom_range(0, 3));
            Write_Data      = 16'($urandom);
            Reserve_Enable  = ($urandom_range(0, 2) == 0);
            Reserve_Address = 2'($urandom_range(0, 3));
            Read_Address1   = 2'($urandom_range(0, 3));
            Read_Address2   = 2'($urandom_range(0, 3));
            Clear_Start     = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 299) == 0) begin
                idle_inputs();
                Reset_n = 1'b0;
            end
            tick();
        end
        idle_inputs();
        Reset_n = 1'b1;
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
